// File: rtl/timer_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_counter_pkg
// Description : Shared constants for the memory-mapped timer/counter. Holds
//               the FSM state encoding, register word offsets (addr[3:2]),
//               CTRL field positions and mode codes. The address bridge
//               imports the same offsets so both sides decode identically.
// Revision    : 1.0  initial release
// ============================================================================
package timer_counter_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_t;

    // Register word offsets, compared against addr[3:2]
    localparam logic [1:0] C_WOFF_CTRL   = 2'd0;   // byte offset 0x0, RW
    localparam logic [1:0] C_WOFF_PRESET = 2'd1;   // byte offset 0x4, RW
    localparam logic [1:0] C_WOFF_COUNT  = 2'd2;   // byte offset 0x8, RO
    localparam logic [1:0] C_WOFF_RSVD   = 2'd3;   // byte offset 0xC, reads 0

    // CTRL field positions
    localparam int C_CTRL_EN_BIT   = 0;
    localparam int C_CTRL_MODE_LSB = 1;
    localparam int C_CTRL_MODE_MSB = 2;
    localparam int C_CTRL_IM_BIT   = 3;
    localparam int C_CTRL_WIDTH    = 4;

    // MODE codes; any nonzero code behaves as auto-reload
    localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] C_MODE_AUTO    = 2'b01;

    // One-shot only for the exact 00 code, so 1x falls into auto-reload
    function automatic logic is_oneshot(input logic [1:0] mode);
        return (mode == C_MODE_ONESHOT);
    endfunction

endpackage : timer_counter_pkg
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : timer_counter
// Description : 32-bit down-counting timer with a three-register bus
//               interface (CTRL, PRESET, COUNT) and a maskable interrupt.
//               A four-state FSM (IDLE -> LOAD -> CNT -> INT) runs from the
//               registered CTRL bits. One-shot mode clears EN on expiry and
//               latches the interrupt; auto-reload restarts and pulses irq
//               for one cycle.
// Ports       : clk    - sole clock, rising edge
//               reset  - synchronous active-high reset
//               addr   - byte address, only addr[3:2] decoded
//               we     - write strobe, pre-qualified by the address bridge
//               din    - 32-bit write data
//               dout   - combinational read data
//               irq    - registered interrupt request
// Revision    : 1.0  initial release
// ============================================================================
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;        // internal interrupt flag, before masking
    logic        r_irq;
    tc_state_t   r_state;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic        w_en_nxt;
    logic [1:0]  w_mode_nxt;
    logic        w_im_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    tc_state_t   w_state_nxt;

    logic [1:0]  w_woff;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_unused;

    assign w_woff      = addr[3:2];
    assign w_wr_ctrl   = we && (w_woff == C_WOFF_CTRL);
    assign w_wr_preset = we && (w_woff == C_WOFF_PRESET);

    // Only addr[3:2] takes part in decoding
    assign w_unused = ^{addr[31:4], addr[1:0]};

    // ------------------------------------------------------------------
    // FSM and register next-state logic. The FSM updates are evaluated
    // first and the bus writes afterwards, so a CTRL write landing on the
    // same edge as the INT state's EN clear takes precedence for every
    // CTRL bit and for the interrupt flag.
    // ------------------------------------------------------------------
    always_comb begin
        w_en_nxt     = r_en;
        w_mode_nxt   = r_mode;
        w_im_nxt     = r_im;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_flag;
        w_state_nxt  = r_state;

        case (r_state)
            ST_IDLE: begin
                if (r_en) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end

            ST_CNT: begin
                if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // Reaching 1 or starting at 0 both expire here, which
                    // keeps the count from wrapping below zero.
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end

            ST_INT: begin
                if (is_oneshot(r_mode)) begin
                    w_en_nxt = 1'b0;
                end else begin
                    w_flag_nxt = 1'b0;
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_wr_ctrl) begin
            w_en_nxt   = din[C_CTRL_EN_BIT];
            w_mode_nxt = din[C_CTRL_MODE_MSB:C_CTRL_MODE_LSB];
            w_im_nxt   = din[C_CTRL_IM_BIT];
            w_flag_nxt = 1'b0;
        end

        if (w_wr_preset) begin
            w_preset_nxt = din;
        end
    end

    // ------------------------------------------------------------------
    // State registers. irq is registered from the next flag and mask, so
    // it tracks (flag AND IM) exactly as those registers update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_mode   <= C_MODE_ONESHOT;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
            r_irq    <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            r_en     <= w_en_nxt;
            r_mode   <= w_mode_nxt;
            r_im     <= w_im_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
            r_flag   <= w_flag_nxt;
            r_irq    <= w_flag_nxt & w_im_nxt;
            r_state  <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read mux, free of side effects
    // ------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        case (w_woff)
            C_WOFF_CTRL:   dout = {{(32-C_CTRL_WIDTH){1'b0}}, r_im, r_mode, r_en};
            C_WOFF_PRESET: dout = r_preset;
            C_WOFF_COUNT:  dout = r_count;
            default:       dout = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule : timer_counter
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_counter
// Description : Self-checking bench for timer_counter. Each scenario task
//               pushes expected read values and irq levels onto a scoreboard
//               queue while driving stimulus, then pops them cycle by cycle
//               and compares against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    always #5 clk = ~clk;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    // adv=1: wait for the next falling edge before sampling this entry
    typedef struct {
        bit          adv;
        logic [1:0]  off;
        logic [31:0] data;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input bit adv, input logic [1:0] off,
                                input logic [31:0] data, input logic ir,
                                input string tag);
        exp_t r;
        r.adv  = adv;
        r.off  = off;
        r.data = data;
        r.irq  = ir;
        r.tag  = tag;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the write
    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        addr = 32'h0000_7F00 | {28'd0, off, 2'b00};
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        din  = 32'd0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        we    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        // A write coinciding with reset must lose
        reset = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_7F00;
        din   = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        sb.push_back(mk(1'b0, C_WOFF_CTRL,   32'd0, 1'b0, "reset_ctrl"));
        sb.push_back(mk(1'b0, C_WOFF_PRESET, 32'd0, 1'b0, "reset_preset"));
        sb.push_back(mk(1'b0, C_WOFF_COUNT,  32'd0, 1'b0, "reset_count"));
        sb.push_back(mk(1'b1, C_WOFF_RSVD,   32'd0, 1'b0, "reset_rsvd"));
        sb.push_back(mk(1'b0, C_WOFF_CTRL,   32'd0, 1'b0, "reset_ctrl_hold"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_oneshot;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd5);
        wr(C_WOFF_CTRL, 32'h9);
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "oneshot_load"));
        for (int j = 2; j <= 7; j++)
            sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'(7 - j), (j == 7),
                            $sformatf("oneshot_count_j%0d", j)));
        for (int j = 8; j <= 10; j++)
            sb.push_back(mk(1'b1, C_WOFF_CTRL, 32'h8, 1'b1,
                            $sformatf("oneshot_ctrl_j%0d", j)));
        sb.push_back(mk(1'b0, C_WOFF_COUNT, 32'd0, 1'b1, "oneshot_count_held"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
        wr(C_WOFF_CTRL, 32'h0);
        sb.push_back(mk(1'b0, C_WOFF_CTRL, 32'h0, 1'b0, "oneshot_clear"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'h0, 1'b0, "oneshot_clear_hold"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_autoreload;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd3);
        wr(C_WOFF_CTRL, 32'hB);
        // First expiry 5 cycles after the CTRL write, then every N+3 = 6
        for (int j = 1; j <= 24; j++)
            sb.push_back(mk(1'b1, C_WOFF_CTRL, 32'hB, (j >= 5 && (j - 5) % 6 == 0),
                            $sformatf("autoreload_j%0d", j)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_mask;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd4);
        wr(C_WOFF_CTRL, 32'h1);
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "mask_load"));
        for (int j = 2; j <= 6; j++)
            sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'(6 - j), 1'b0,
                            $sformatf("mask_count_j%0d", j)));
        sb.push_back(mk(1'b1, C_WOFF_CTRL, 32'h0, 1'b0, "mask_en_cleared"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
        // Unmasking afterwards must not reveal the stale flag
        wr(C_WOFF_CTRL, 32'h8);
        sb.push_back(mk(1'b0, C_WOFF_CTRL, 32'h8, 1'b0, "mask_unmask_j0"));
        sb.push_back(mk(1'b1, C_WOFF_CTRL, 32'h8, 1'b0, "mask_unmask_j1"));
        sb.push_back(mk(1'b1, C_WOFF_CTRL, 32'h8, 1'b0, "mask_unmask_j2"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_reset_midcount;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd10);
        wr(C_WOFF_CTRL, 32'h9);
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "midrst_load"));
        for (int j = 2; j <= 6; j++)
            sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'(12 - j), 1'b0,
                            $sformatf("midrst_count_j%0d", j)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk(1'b0, C_WOFF_CTRL,   32'd0, 1'b0, "midrst_ctrl"));
        sb.push_back(mk(1'b0, C_WOFF_PRESET, 32'd0, 1'b0, "midrst_preset"));
        sb.push_back(mk(1'b0, C_WOFF_COUNT,  32'd0, 1'b0, "midrst_count"));
        for (int j = 1; j <= 4; j++)
            sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0,
                            $sformatf("midrst_idle_j%0d", j)));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_ignored_writes;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd7);
        wr(C_WOFF_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        sb.push_back(mk(1'b0, C_WOFF_COUNT, 32'd6, 1'b0, "ign_count_running"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
        // Disabling mid-count: one more decrement, then COUNT is held
        wr(C_WOFF_CTRL, 32'h0);
        @(negedge clk);
        wr(C_WOFF_COUNT, 32'h1234);
        wr(C_WOFF_RSVD, 32'hDEAD_BEEF);
        wr(C_WOFF_CTRL, 32'hFFFF_FFFF);
        sb.push_back(mk(1'b0, C_WOFF_COUNT, 32'd5, 1'b0, "ign_count_held"));
        sb.push_back(mk(1'b0, C_WOFF_CTRL,  32'hF, 1'b0, "ign_ctrl_ones"));
        sb.push_back(mk(1'b0, C_WOFF_RSVD,  32'd0, 1'b0, "ign_rsvd_zero"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd2);
        wr(C_WOFF_CTRL, 32'h9);
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "b2b_load"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd2, 1'b0, "b2b_count_j2"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd1, 1'b0, "b2b_count_j3"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b1, "b2b_int_j4"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
        // CTRL write on the edge where INT would clear EN: the write wins
        wr(C_WOFF_CTRL, 32'hB);
        sb.push_back(mk(1'b0, C_WOFF_CTRL,  32'hB, 1'b0, "b2b_write_wins"));
        sb.push_back(mk(1'b1, C_WOFF_CTRL,  32'hB, 1'b0, "b2b_load2"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd2, 1'b0, "b2b_count2_j7"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd1, 1'b0, "b2b_count2_j8"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b1, "b2b_pulse_j9"));
        sb.push_back(mk(1'b1, C_WOFF_CTRL,  32'hB, 1'b0, "b2b_pulse_end"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    task automatic test_zero_preset;
        exp_t e;
        do_reset();
        wr(C_WOFF_PRESET, 32'd0);
        wr(C_WOFF_CTRL, 32'h9);
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "zero_load"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b0, "zero_cnt"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b1, "zero_int"));
        sb.push_back(mk(1'b1, C_WOFF_COUNT, 32'd0, 1'b1, "zero_hold_j4"));
        sb.push_back(mk(1'b1, C_WOFF_CTRL,  32'h8, 1'b1, "zero_ctrl_j5"));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.adv) @(negedge clk);
            addr = 32'h0000_7F00 | {28'd0, e.off, 2'b00};
            #1;
            checks++;
            if (dout !== e.data) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", e.tag, dout, e.data);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        din   = 32'd0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_reset_midcount();
        test_ignored_writes();
        test_back_to_back();
        test_zero_preset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_counter
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have no parameters; register map and field positions are fixed constants.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port addr, input, 32, byte address from the address bridge; only addr[3:2] decoded.
REQ-005 SHALL have port we, input, 1, write strobe, already range-qualified by the bridge (TC0WE/TC1WE).
REQ-006 SHALL have port din, input, 32, full-word write data; no byte-lane masking.
REQ-007 SHALL have port dout, output, 32, combinational read data to the bridge (TC0Data/TC1Data).
REQ-008 SHALL have port irq, output, 1, registered interrupt request to the CPU.

Function
REQ-009 SHALL decode word offsets: 0x0 CTRL (RW), 0x4 PRESET (RW), 0x8 COUNT (RO), 0xC reserved.
REQ-010 SHALL implement CTRL[0]=EN, CTRL[2:1]=MODE (00 one-shot, 01 auto-reload, 1x treated as 01), CTRL[3]=IM; CTRL[31:4] store nothing and read 0.
REQ-011 SHALL, on we with addr[3:2]=00, load CTRL[3:0]=din[3:0] and clear the internal irq flag at the same edge.
REQ-012 SHALL, on we with addr[3:2]=01, load PRESET=din; a running count is unaffected until the next LOAD.
REQ-013 SHALL ignore writes to offsets 0x8 and 0xC.
REQ-014 SHALL drive dout = CTRL (zero-extended), PRESET or COUNT by addr[3:2]; 0 for 0xC; no read side effects.
REQ-015 SHALL use a 4-state FSM: IDLE, LOAD, CNT, INT, evaluated on registered CTRL.
REQ-016 IDLE: EN=1 -> LOAD, else stay; COUNT holds.
REQ-017 LOAD: COUNT<=PRESET -> CNT (unconditionally).
REQ-018 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; else (COUNT 1 or 0) COUNT<=0, irq flag<=1 -> INT.
REQ-019 INT, one-shot: CTRL.EN<=0, irq flag held -> IDLE; auto-reload: irq flag<=0 -> IDLE.
REQ-020 irq SHALL equal registered (irq flag AND CTRL.IM); one-shot holds until CTRL write or reset; auto-reload gives a 1-cycle pulse.
REQ-021 Timing SHALL be: write CTRL.EN=1 at edge t; LOAD at t+1; COUNT=PRESET=N at t+2; COUNT reaches 0 and state INT at t+2+N (N>=1; N=0 behaves as N=1).
REQ-022 Auto-reload period SHALL be N+3 cycles (IDLE, LOAD, N x CNT, INT).
REQ-023 On a CTRL write in the same cycle as INT clearing EN, the software write SHALL win for all CTRL bits and the irq flag.
REQ-024 COUNT SHALL never wrap below 0; 32-bit unsigned arithmetic only.

Reset
REQ-025 On reset SHALL set CTRL=0, PRESET=0, COUNT=0, irq flag=0, irq=0, FSM=IDLE; reset overrides a coincident we.
REQ-026 Reset mid-count SHALL abort the count without irq; dout then reads 0 at every offset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, register word offsets, CTRL field positions and mode codes; the address bridge uses the same offset constants.
REQ-028 SHALL be one flat module with no sub-module; instantiated twice (TC0 at 0x7F00, TC1 at 0x7F10).

Verification
REQ-029 PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on successive cycles; irq rises when COUNT=0 and stays high; CTRL reads 0x8; write CTRL=0 -> irq low next cycle.
REQ-030 PRESET=3, CTRL=0xB -> irq 1-cycle pulses exactly 6 cycles apart; CTRL.EN stays 1.
REQ-031 PRESET=4, CTRL=0x1 (IM=0) -> count completes, irq stays 0; then write CTRL=0x8 -> irq stays 0 (flag cleared by write).
REQ-032 PRESET=10, CTRL=0x9, reset asserted when COUNT=6 -> all registers read 0, irq 0, no further counting.
REQ-033 Write 0x1234 to offset 0x8 and 0xFFFFFFFF to CTRL -> COUNT unchanged, CTRL reads 0xF, offset 0xC reads 0.
REQ-034 PRESET=0, CTRL=0x9 -> INT reached 1 cycle after LOAD+1; irq asserted, COUNT stays 0.
